// File: rtl/modaddsub_pipe.sv
// Pipelined modular adder/subtractor for moduli of the form q = qH*2^W + 1.
// Three optional register stages (input, post-add, output) share one stall enable.
module modaddsub_pipe #(
    parameter int LOGQ   = 64,
    parameter int LOGQH  = 47,
    parameter int TAGW   = 8,
    parameter int FF_IN  = 1,
    parameter int FF_ADD = 1,
    parameter int FF_OUT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op,
    input  logic [LOGQ-1:0]   A,
    input  logic [LOGQ-1:0]   B,
    input  logic [LOGQH-1:0]  qH,
    input  logic [TAGW-1:0]   tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOGQ-1:0]   C,
    output logic [TAGW-1:0]   out_tag
);

    localparam int W = LOGQ - LOGQH;
    localparam int L = FF_IN + FF_ADD + FF_OUT;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and a stalled result holds until taken.
    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = (L > 0) ? en : out_ready;

    logic [LOGQ-1:0] q;
    assign q = {qH, {(W-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------- input stage
    logic             s1_valid;
    logic             s1_op;
    logic [LOGQ-1:0]  s1_a;
    logic [LOGQ-1:0]  s1_b;
    logic [TAGW-1:0]  s1_tag;

    generate
        if (FF_IN != 0) begin : g_in
            logic            valid_q;
            logic            op_q;
            logic [LOGQ-1:0] a_q;
            logic [LOGQ-1:0] b_q;
            logic [TAGW-1:0] tag_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                end else if (en) begin
                    valid_q <= in_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    op_q  <= op;
                    a_q   <= A;
                    b_q   <= B;
                    tag_q <= tag;
                end
            end

            assign s1_valid = valid_q;
            assign s1_op    = op_q;
            assign s1_a     = a_q;
            assign s1_b     = b_q;
            assign s1_tag   = tag_q;
        end else begin : g_in_bypass
            assign s1_valid = in_valid;
            assign s1_op    = op;
            assign s1_a     = A;
            assign s1_b     = B;
            assign s1_tag   = tag;
        end
    endgenerate

    // ----------------------------------------------------------- add/sub stage
    // Raw sum or difference, one bit wider so the sign/carry survives to the fix-up.
    logic [LOGQ:0] r_d;

    always_comb begin
        if (s1_op) begin
            r_d = {1'b0, s1_a} - {1'b0, s1_b};
        end else begin
            r_d = {1'b0, s1_a} + {1'b0, s1_b};
        end
    end

    logic             s2_valid;
    logic             s2_op;
    logic [LOGQ:0]    s2_r;
    logic [TAGW-1:0]  s2_tag;

    generate
        if (FF_ADD != 0) begin : g_add
            logic            valid_q;
            logic            op_q;
            logic [LOGQ:0]   r_q;
            logic [TAGW-1:0] tag_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                end else if (en) begin
                    valid_q <= s1_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    op_q  <= s1_op;
                    r_q   <= r_d;
                    tag_q <= s1_tag;
                end
            end

            assign s2_valid = valid_q;
            assign s2_op    = op_q;
            assign s2_r     = r_q;
            assign s2_tag   = tag_q;
        end else begin : g_add_bypass
            assign s2_valid = s1_valid;
            assign s2_op    = s1_op;
            assign s2_r     = r_d;
            assign s2_tag   = s1_tag;
        end
    endgenerate

    // ------------------------------------------------------------ reduce stage
    // Operands are below q, so a single conditional subtract/add of q suffices.
    logic [LOGQ:0]   rq;
    logic [LOGQ-1:0] c_d;

    always_comb begin
        rq = s2_r - {1'b0, q};
        if (s2_op) begin
            c_d = s2_r[LOGQ] ? (s2_r[LOGQ-1:0] + q) : s2_r[LOGQ-1:0];
        end else begin
            c_d = rq[LOGQ] ? s2_r[LOGQ-1:0] : rq[LOGQ-1:0];
        end
    end

    generate
        if (FF_OUT != 0) begin : g_out
            logic            valid_q;
            logic [LOGQ-1:0] c_q;
            logic [TAGW-1:0] tag_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    c_q     <= '0;
                    tag_q   <= '0;
                end else if (en) begin
                    valid_q <= s2_valid;
                    c_q     <= c_d;
                    tag_q   <= s2_tag;
                end
            end

            assign out_valid = valid_q;
            assign C         = c_q;
            assign out_tag   = tag_q;
        end else begin : g_out_bypass
            assign out_valid = s2_valid;
            assign C         = c_d;
            assign out_tag   = s2_tag;
        end
    endgenerate

endmodule

// File: tb/tb_modaddsub_pipe.sv
// Bench for modaddsub_pipe: a registered instance (L=3) and a fully combinational
// instance (L=0) share one stimulus stream and are checked against a modular-arithmetic model.
module tb_modaddsub_pipe;

    localparam int LOGQ  = 8;
    localparam int LOGQH = 4;
    localparam int TAGW  = 8;
    localparam int Q     = 241;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             op_i = 1'b0;
    logic [LOGQ-1:0]  a_i = '0;
    logic [LOGQ-1:0]  b_i = '0;
    logic [LOGQH-1:0] qh_i = 4'd15;
    logic [TAGW-1:0]  tag_i = '0;
    logic             out_ready = 1'b1;

    logic             in_ready, out_valid;
    logic [LOGQ-1:0]  c_o;
    logic [TAGW-1:0]  out_tag;
    logic             in_ready_z, out_valid_z;
    logic [LOGQ-1:0]  c_z;
    logic [TAGW-1:0]  out_tag_z;

    modaddsub_pipe #(.LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW),
                     .FF_IN(1), .FF_ADD(1), .FF_OUT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op_i), .A(a_i), .B(b_i), .qH(qh_i), .tag(tag_i),
        .out_valid(out_valid), .out_ready(out_ready), .C(c_o), .out_tag(out_tag)
    );

    modaddsub_pipe #(.LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW),
                     .FF_IN(0), .FF_ADD(0), .FF_OUT(0)) dut_comb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z),
        .op(op_i), .A(a_i), .B(b_i), .qH(qh_i), .tag(tag_i),
        .out_valid(out_valid_z), .out_ready(out_ready), .C(c_z), .out_tag(out_tag_z)
    );

    // ------------------------------------------------------------ clock/reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [TAGW+LOGQ-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    function automatic logic [LOGQ-1:0] ref_mod(input bit sub, input int a, input int b);
        int r;
        if (sub) r = (a - b + Q) % Q;
        else     r = (a + b) % Q;
        return r[LOGQ-1:0];
    endfunction

    int               rdy_run = 0;
    logic [2:0]       acc_hist = '0;
    bit               prev_stall = 1'b0;
    logic [LOGQ-1:0]  prev_c = '0;
    logic [TAGW-1:0]  prev_tag = '0;

    always @(negedge clk) begin
        logic [TAGW+LOGQ-1:0] e;
        bit accepted;
        if (rst) begin
            exp_q.delete();
            rdy_run    = 0;
            acc_hist   = '0;
            prev_stall = 1'b0;
        end else begin
            check("comb_in_ready", in_ready_z, out_ready);
            check("comb_out_valid", out_valid_z, in_valid);
            if (in_valid) begin
                check("comb_c", c_z, ref_mod(op_i, a_i, b_i));
                check("comb_tag", out_tag_z, tag_i);
            end
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_c", c_o, prev_c);
                check("stall_tag", out_tag, prev_tag);
            end
            if (rdy_run >= 3) check("latency", out_valid, acc_hist[2]);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_c", c_o, e[LOGQ-1:0]);
                    check("result_tag", out_tag, e[TAGW+LOGQ-1:LOGQ]);
                end
            end
            accepted = in_valid && in_ready;
            if (accepted) exp_q.push_back({tag_i, ref_mod(op_i, a_i, b_i)});
            acc_hist   = {acc_hist[1:0], accepted};
            rdy_run    = out_ready ? rdy_run + 1 : 0;
            prev_stall = out_valid && !out_ready;
            prev_c     = c_o;
            prev_tag   = out_tag;
        end
    end

    // ------------------------------------------------------------ driver tasks
    task automatic cycle(input bit v, input bit o, input logic [LOGQ-1:0] a,
                         input logic [LOGQ-1:0] b, input logic [TAGW-1:0] t,
                         input bit ordy, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        op_i      = o;
        a_i       = a;
        b_i       = b;
        tag_i     = t;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
    endtask

    task automatic latency_op(input bit o, input logic [LOGQ-1:0] a,
                              input logic [LOGQ-1:0] b, input logic [TAGW-1:0] t,
                              input string name);
        bit acc;
        int lat;
        cycle(1'b1, o, a, b, t, 1'b1, acc);
        check({name, "_accept"}, acc, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = i;
        end
        check({name, "_latency"}, lat, 3);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        bit acc;
        int k;
        logic [LOGQ-1:0] va[8], vb[8];
        bit              vo[8];

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_c", c_o, 0);
        check("reset_tag", out_tag, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic add with explicit three-cycle latency.
        latency_op(1'b0, 8'd200, 8'd100, 8'h11, "add_200_100");
        check("add_200_100_c", c_o, 59);
        check("add_200_100_tag", out_tag, 8'h11);

        // Directed values and boundaries, back to back.
        vo = '{1, 1, 0, 0, 1, 1, 0, 0};
        va = '{8'd10, 8'd20, 8'd120, 8'd240, 8'd77, 8'd99, 8'd0, 8'd240};
        vb = '{8'd20, 8'd10, 8'd121, 8'd0, 8'd77, 8'd0, 8'd0, 8'd240};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vo[i], va[i], vb[i], 8'(8'h20 + i), 1'b1, acc);
            check("directed_accept", acc, 1);
        end
        repeat (5) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);

        // Five back-to-back ops with a three-cycle downstream stall.
        k = 0;
        for (int c = 0; c < 30 && k < 5; c++) begin
            bit ordy;
            ordy = !(c >= 3 && c < 6);
            cycle(1'b1, k[0], 8'(50 + 37 * k), 8'(200 - 11 * k), 8'(8'h40 + k), ordy, acc);
            if (!ordy) check("stall_blocks_input", acc, 0);
            if (acc) k++;
        end
        check("stall_ops_sent", k, 5);
        repeat (6) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);

        // Alternating valid with free-flowing output.
        for (int c = 0; c < 20; c++) begin
            cycle(c % 2 == 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, Q - 1)),
                  8'($urandom_range(0, Q - 1)), 8'(c), 1'b1, acc);
        end
        repeat (5) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);

        // Reset with operations in flight, one already at the output.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'(100 + i), 8'(60 + i), 8'(8'h70 + i), 1'b1, acc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_c", c_o, 0);
        check("async_reset_tag", out_tag, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale_after_reset", out_valid, 0);
        end
        latency_op(1'b1, 8'd5, 8'd9, 8'h99, "post_reset");
        check("post_reset_c", c_o, 237);

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, Q - 1)), 8'($urandom_range(0, Q - 1)),
                  8'($urandom), $urandom_range(0, 3) != 0, acc);
        end

        // Drain with a bounded wait.
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
        end
        repeat (2) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
